// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter
//   Round-robin arbiter that shares one core bus between NUM_REQ requesters.
//   One transaction at a time: the winner's instruction/address/value go on
//   the bus for a single cycle, the block then waits RESULT_LATENCY cycles,
//   captures bus_result_i and returns it with a one-cycle done pulse.
//
// Ports
//   clk_i              system clock
//   rst_i              synchronous reset, active-high
//   req_i              per-requester request, held until done_o
//   instr_i/addr_i/value_i  packed per-requester fields, requester k at [k*W +: W]
//   grant_o            one-hot current bus owner (ISSUE through RESP)
//   done_o             one-cycle pulse to the owner, result_o valid
//   result_o           last captured result, shared by all requesters
//   busy_o             high whenever the FSM is not IDLE
//   bus_instruction_o  core bus instruction (8'h00 = NOP outside ISSUE)
//   bus_address_o      core bus address
//   bus_value_o        core bus value
//   bus_result_i       core bus result
module core_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int INSTR_W        = 8,
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 32,
    parameter int RESULT_LATENCY = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*INSTR_W-1:0]  instr_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   value_i,
    output logic [NUM_REQ-1:0]          grant_o,
    output logic [NUM_REQ-1:0]          done_o,
    output logic [DATA_W-1:0]           result_o,
    output logic                        busy_o,
    output logic [INSTR_W-1:0]          bus_instruction_o,
    output logic [ADDR_W-1:0]           bus_address_o,
    output logic [DATA_W-1:0]           bus_value_o,
    input  logic [DATA_W-1:0]           bus_result_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((RESULT_LATENCY > 0) ? RESULT_LATENCY - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     last_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic [NUM_REQ-1:0]   win_onehot;

    logic [INSTR_W-1:0]   instr_arr [NUM_REQ];
    logic [ADDR_W-1:0]    addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]    value_arr [NUM_REQ];

    logic [NUM_REQ-1:0]   grant_d, done_d;
    logic [DATA_W-1:0]    result_d, value_d;
    logic                 busy_d;
    logic [INSTR_W-1:0]   instr_d;
    logic [ADDR_W-1:0]    addr_d;

    // Unpack the per-requester fields so the winner can be selected by index.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            instr_arr[k] = instr_i[k*INSTR_W +: INSTR_W];
            addr_arr[k]  = addr_i[k*ADDR_W +: ADDR_W];
            value_arr[k] = value_i[k*DATA_W +: DATA_W];
        end
    end

    // Round-robin search: start one past the previous winner and wrap, so
    // the previous winner is considered last.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = '0;
        win_idx   = last_q;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;

    // State register and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            last_q            <= LAST_RST;
            grant_o           <= '0;
            done_o            <= '0;
            result_o          <= '0;
            busy_o            <= 1'b0;
            bus_instruction_o <= '0;
            bus_address_o     <= '0;
            bus_value_o       <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            if (state_q == IDLE && win_found) begin
                last_q <= win_idx;
            end
            grant_o           <= grant_d;
            done_o            <= done_d;
            result_o          <= result_d;
            busy_o            <= busy_d;
            bus_instruction_o <= instr_d;
            bus_address_o     <= addr_d;
            bus_value_o       <= value_d;
        end
    end

    // Next-state logic; WAIT lasts exactly RESULT_LATENCY cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (RESULT_LATENCY == 0) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: computes the values the outputs take in the next state,
    // so every output comes straight from a flop.
    always_comb begin
        grant_d  = grant_o;
        done_d   = '0;
        result_d = result_o;
        busy_d   = (state_d != IDLE);
        instr_d  = '0;
        addr_d   = bus_address_o;
        value_d  = bus_value_o;
        case (state_d)
            ISSUE: begin
                grant_d = win_onehot;
                instr_d = instr_arr[win_idx];
                addr_d  = addr_arr[win_idx];
                value_d = value_arr[win_idx];
            end
            RESP: begin
                // Edge entering RESP is the one that ends the last wait cycle.
                done_d   = grant_o;
                result_d = bus_result_i;
            end
            IDLE:    grant_d = '0;
            default: ;
        endcase
    end

endmodule
